// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared widths and types for the AXI interconnect write path
package axi_ic_pkg;
  localparam int AXI_M  = 2;
  localparam int AXI_S  = 2;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;

  // Index width that stays at least 1 bit for single-entry fabrics.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SEL_W  = idx_w(AXI_S);
  localparam int MSEL_W = idx_w(AXI_M);

  typedef struct packed {
    logic [SEL_W-1:0] slave;
    logic [LEN_W-1:0] len;
  } mq_entry_t;
endpackage

// File: rtl/order_fifo.sv
// rtl/order_fifo.sv - small ordering FIFO with registered head, any depth >= 1
module order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Explicit wrap so non-power-of-2 depths never index past the last slot.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/write_data_scheduler.sv
// rtl/write_data_scheduler.sv - W-channel ordering per master and per slave; WLEN_CHECK_EN adds burst length checking
module write_data_scheduler
  import axi_ic_pkg::*;
#(
  parameter int M = AXI_M,
  parameter int S = AXI_S,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  localparam int SLV_W = idx_w(S)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [M-1:0]       aw_fire_f,
  input  logic [M*SLV_W-1:0] aw_sel_f,
  input  logic [M*4-1:0]     aw_len_f,
  output logic [M-1:0]       aw_space_f,
  input  logic [M-1:0]       w_fire_f,
  input  logic [M-1:0]       w_last_f,
  output logic [M-1:0]       W_grant_f,
  output logic [M*SLV_W-1:0] W_sel_f,
  output logic [M-1:0]       w_len_err_f
);
  localparam int MST_W = idx_w(M);
  localparam int NS    = 1 << SLV_W;
  localparam int CNT_W = $clog2(NUM_OUTSTANDING_TRANS + 1);
`ifdef WLEN_CHECK_EN
  localparam int MQ_W  = SLV_W + LEN_W;
`else
  localparam int MQ_W  = SLV_W;
`endif

  logic [SLV_W-1:0] aw_sel   [M];
  logic [SLV_W-1:0] head_slv [M];
  logic [MQ_W-1:0]  mq_din   [M];
  logic [MQ_W-1:0]  mq_head  [M];
  logic [M-1:0]     mq_push;
  logic [M-1:0]     mq_pop;
  logic [M-1:0]     mq_full;
  logic [M-1:0]     mq_empty;
  logic [CNT_W-1:0] mq_cnt_unused [M];

  // Slave-side views padded to a power of two so an unused select reads as full/empty.
  logic [MST_W-1:0] sq_din    [S];
  logic [S-1:0]     sq_push;
  logic [S-1:0]     sq_pop;
  logic [NS-1:0]    sq_full_x;
  logic [NS-1:0]    sq_empty_x;
  logic [MST_W-1:0] sq_head_x [NS];
  logic [CNT_W-1:0] sq_cnt_unused [S];

  for (genvar m = 0; m < M; m++) begin : g_mst
    assign aw_sel[m]   = aw_sel_f[m*SLV_W +: SLV_W];
    assign head_slv[m] = mq_head[m][MQ_W-1 -: SLV_W];

    assign aw_space_f[m] = !mq_full[m] && !sq_full_x[aw_sel[m]];
    assign mq_push[m]    = aw_fire_f[m] && aw_space_f[m];

    assign W_grant_f[m] = !mq_empty[m] && !sq_empty_x[head_slv[m]]
                          && (sq_head_x[head_slv[m]] == MST_W'(m));
    assign W_sel_f[m*SLV_W +: SLV_W] = W_grant_f[m] ? head_slv[m] : '0;
    assign mq_pop[m] = w_fire_f[m] && w_last_f[m] && W_grant_f[m];

`ifdef WLEN_CHECK_EN
    logic [LEN_W-1:0] beat_cnt;
    logic             len_err;

    assign mq_din[m]      = {aw_sel[m], aw_len_f[m*4 +: 4]};
    assign w_len_err_f[m] = len_err;

    // Beat index within the current burst; the last beat must land exactly on AWLEN.
    always_ff @(posedge clk) begin
      if (clr) begin
        beat_cnt <= '0;
        len_err  <= 1'b0;
      end else begin
        len_err <= 1'b0;
        if (w_fire_f[m] && W_grant_f[m]) begin
          if (w_last_f[m]) begin
            len_err  <= (beat_cnt != mq_head[m][LEN_W-1:0]);
            beat_cnt <= '0;
          end else begin
            len_err  <= (beat_cnt == mq_head[m][LEN_W-1:0]);
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
`else
    assign mq_din[m]      = aw_sel[m];
    assign w_len_err_f[m] = 1'b0;
`endif

    order_fifo #(
      .WIDTH (MQ_W),
      .DEPTH (NUM_OUTSTANDING_TRANS)
    ) u_mq (
      .clk       (clk),
      .clr       (clr),
      .push      (mq_push[m]),
      .push_data (mq_din[m]),
      .pop       (mq_pop[m]),
      .full      (mq_full[m]),
      .empty     (mq_empty[m]),
      .head      (mq_head[m]),
      .count     (mq_cnt_unused[m])
    );
  end

`ifndef WLEN_CHECK_EN
  logic len_unused;
  assign len_unused = ^aw_len_f;
`endif

  always_comb begin
    for (int s = 0; s < S; s++) begin
      sq_push[s] = 1'b0;
      sq_pop[s]  = 1'b0;
      sq_din[s]  = '0;
      for (int m = 0; m < M; m++) begin
        if (mq_push[m] && aw_sel[m] == SLV_W'(s)) begin
          sq_push[s] = 1'b1;
          sq_din[s]  = MST_W'(m);
        end
        if (mq_pop[m] && head_slv[m] == SLV_W'(s)) sq_pop[s] = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_slv
    order_fifo #(
      .WIDTH (MST_W),
      .DEPTH (NUM_OUTSTANDING_TRANS)
    ) u_sq (
      .clk       (clk),
      .clr       (clr),
      .push      (sq_push[s]),
      .push_data (sq_din[s]),
      .pop       (sq_pop[s]),
      .full      (sq_full_x[s]),
      .empty     (sq_empty_x[s]),
      .head      (sq_head_x[s]),
      .count     (sq_cnt_unused[s])
    );
  end

  for (genvar s = S; s < NS; s++) begin : g_pad
    assign sq_full_x[s]  = 1'b1;
    assign sq_empty_x[s] = 1'b1;
    assign sq_head_x[s]  = '0;
  end

  // The write arbiter never grants one slave to two masters, and the crossbar
  // only forwards beats for a granted master.
  logic aw_collide;
  always_comb begin
    aw_collide = 1'b0;
    for (int a = 0; a < M; a++) begin
      for (int b = a + 1; b < M; b++) begin
        if (aw_fire_f[a] && aw_fire_f[b] && aw_sel[a] == aw_sel[b]) aw_collide = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      assert (!aw_collide);
      assert ((w_fire_f & ~W_grant_f) == '0);
    end
  end
endmodule

// File: tb/tb_write_data_scheduler.sv
// tb/tb_write_data_scheduler.sv - queue-model scoreboard bench for write_data_scheduler (WLEN_CHECK_EN aware)
module tb_write_data_scheduler;
  localparam int M  = 2;
  localparam int S  = 2;
  localparam int D  = 2;
  localparam int SW = 1;
`ifdef WLEN_CHECK_EN
  localparam logic [M-1:0] ERR6 = 2'b01;
`else
  localparam logic [M-1:0] ERR6 = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [M-1:0]    aw_fire_f = '0;
  logic [M*SW-1:0] aw_sel_f  = '0;
  logic [M*4-1:0]  aw_len_f  = '0;
  logic [M-1:0]    w_fire_f  = '0;
  logic [M-1:0]    w_last_f  = '0;
  logic [M-1:0]    aw_space_f;
  logic [M-1:0]    W_grant_f;
  logic [M*SW-1:0] W_sel_f;
  logic [M-1:0]    w_len_err_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_data_scheduler #(.M(M), .S(S), .NUM_OUTSTANDING_TRANS(D)) dut (
    .clk         (clk),
    .clr         (clr),
    .aw_fire_f   (aw_fire_f),
    .aw_sel_f    (aw_sel_f),
    .aw_len_f    (aw_len_f),
    .aw_space_f  (aw_space_f),
    .w_fire_f    (w_fire_f),
    .w_last_f    (w_last_f),
    .W_grant_f   (W_grant_f),
    .W_sel_f     (W_sel_f),
    .w_len_err_f (w_len_err_f)
  );

  typedef struct {
    int slave;
    int len;
  } ent_t;

  ent_t         mq [M][$];
  int           sq [S][$];
  int           mcnt [M];
  logic [M-1:0] err_exp = '0;
  bit           model_ok = 1'b0;

  function automatic bit mgrant(int m);
    if (mq[m].size() == 0) return 1'b0;
    return (sq[mq[m][0].slave].size() != 0) && (sq[mq[m][0].slave][0] == m);
  endfunction

  function automatic bit mspace(int m, int s);
    return (mq[m].size() < D) && (sq[s].size() < D);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-master and per-slave order queues advanced at each clock edge.
  always @(posedge clk) begin
    bit   g  [M];
    int   hs [M];
    bit   pu [M];
    ent_t e;
    if (clr) begin
      for (int m = 0; m < M; m++) begin
        mq[m].delete();
        mcnt[m] = 0;
      end
      for (int s = 0; s < S; s++) sq[s].delete();
      err_exp  = '0;
      model_ok = 1'b1;
    end else begin
      for (int m = 0; m < M; m++) begin
        g[m]  = mgrant(m);
        hs[m] = g[m] ? mq[m][0].slave : 0;
        pu[m] = aw_fire_f[m] && mspace(m, int'(aw_sel_f[m*SW +: SW]));
        err_exp[m] = 1'b0;
        if (w_fire_f[m] && g[m]) begin
          if (w_last_f[m]) begin
            err_exp[m] = (mcnt[m] != mq[m][0].len);
            mcnt[m] = 0;
          end else begin
            err_exp[m] = (mcnt[m] == mq[m][0].len);
            mcnt[m] = (mcnt[m] + 1) % 16;
          end
        end
      end
      for (int m = 0; m < M; m++) begin
        if (g[m] && w_fire_f[m] && w_last_f[m]) begin
          void'(mq[m].pop_front());
          void'(sq[hs[m]].pop_front());
        end
      end
      for (int m = 0; m < M; m++) begin
        if (pu[m]) begin
          e.slave = int'(aw_sel_f[m*SW +: SW]);
          e.len   = int'(aw_len_f[m*4 +: 4]);
          mq[m].push_back(e);
          sq[e.slave].push_back(m);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [M-1:0]    eg;
    logic [M-1:0]    esp;
    logic [M-1:0]    eerr;
    logic [M*SW-1:0] es;
    if (model_ok) begin
      for (int m = 0; m < M; m++) begin
        eg[m] = mgrant(m);
        es[m*SW +: SW] = eg[m] ? SW'(mq[m][0].slave) : '0;
        esp[m] = mspace(m, int'(aw_sel_f[m*SW +: SW]));
      end
`ifdef WLEN_CHECK_EN
      eerr = err_exp;
`else
      eerr = '0;
`endif
      check("cyc_grant", W_grant_f, eg);
      check("cyc_sel", W_sel_f, es);
      check("cyc_space", aw_space_f, esp);
      check("cyc_len_err", w_len_err_f, eerr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aw_fire_f = '0;
    w_fire_f  = '0;
    w_last_f  = '0;
  endtask

  initial begin
    logic [S-1:0] used;
    int           s;

    clr = 1'b1;
    idle();
    tick();
    tick();
    #1;
    check("rst_grant", W_grant_f, 0);
    check("rst_space", aw_space_f, 2'b11);
    check("rst_err", w_len_err_f, 0);
    check("rst_sel", W_sel_f, 0);
    clr = 1'b0;

    // Single 4-beat burst M0 -> S1.
    aw_fire_f = 2'b01; aw_sel_f = 2'b01; aw_len_f = 8'h03;
    tick(); idle();
    #1;
    check("t2_grant", W_grant_f[0], 1);
    check("t2_sel", W_sel_f[0], 1);
    for (int i = 0; i < 4; i++) begin
      w_fire_f = 2'b01;
      w_last_f = (i == 3) ? 2'b01 : 2'b00;
      #1 check("t2_hold", W_grant_f[0], 1);
      tick();
    end
    idle();
    #1 check("t2_done", W_grant_f, 2'b00);

    // Two masters to S0 on consecutive cycles: slave order enforced.
    aw_fire_f = 2'b01; aw_sel_f = 2'b00; aw_len_f = '0;
    tick();
    aw_fire_f = 2'b10;
    tick(); idle();
    #1 check("t3_m0_only", W_grant_f, 2'b01);
    w_fire_f = 2'b01; w_last_f = 2'b01;
    tick(); idle();
    #1;
    check("t3_m1_grant", W_grant_f, 2'b10);
    check("t3_m1_sel", W_sel_f, 2'b00);
    w_fire_f = 2'b10; w_last_f = 2'b10;
    tick(); idle();
    #1 check("t3_drain", W_grant_f, 2'b00);

    // Disjoint slaves granted concurrently.
    aw_fire_f = 2'b11; aw_sel_f = 2'b10;
    tick(); idle();
    #1;
    check("t4_grant", W_grant_f, 2'b11);
    check("t4_sel", W_sel_f, 2'b10);
    w_fire_f = 2'b11; w_last_f = 2'b11;
    tick(); idle();
    #1 check("t4_drain", W_grant_f, 2'b00);

    // Full FIFOs block AW; same-cycle pop does not free space early.
    aw_fire_f = 2'b01; aw_sel_f = 2'b00;
    tick();
    tick(); idle();
    #1 check("t5_space_full", aw_space_f, 2'b00);
    w_fire_f = 2'b01; w_last_f = 2'b01;
    #1 check("t5_no_early_free", aw_space_f, 2'b00);
    tick(); idle();
    #1 check("t5_space_back", aw_space_f, 2'b11);
    w_fire_f = 2'b01; w_last_f = 2'b01;
    tick(); idle();
    #1 check("t5_drain", W_grant_f, 2'b00);

    // Short burst: WLAST on first beat of a len=1 burst.
    aw_fire_f = 2'b01; aw_sel_f = 2'b00; aw_len_f = 8'h01;
    tick(); idle();
    w_fire_f = 2'b01; w_last_f = 2'b01;
    tick(); idle();
    #1;
    check("t6_err", w_len_err_f, ERR6);
    check("t6_popped", W_grant_f, 2'b00);
    tick();
    check("t6_pulse_end", w_len_err_f, 2'b00);

    // Clear mid-burst drops everything.
    aw_fire_f = 2'b01; aw_sel_f = 2'b01; aw_len_f = 8'h02;
    tick(); idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1 check("clr_drop", W_grant_f, 2'b00);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle();
      clr  = ($urandom_range(0, 299) == 0);
      used = '0;
      for (int m = 0; m < M; m++) begin
        s = $urandom_range(0, S - 1);
        aw_sel_f[m*SW +: SW] = SW'(s);
        aw_len_f[m*4 +: 4]   = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0 && mspace(m, s) && !used[s]) begin
          aw_fire_f[m] = 1'b1;
          used[s] = 1'b1;
        end
        if (mgrant(m) && $urandom_range(0, 3) != 0) begin
          w_fire_f[m] = 1'b1;
          w_last_f[m] = (mcnt[m] == mq[m][0].len) ^ ($urandom_range(0, 7) == 0);
        end
      end
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
